dma_bus_arbiter: RTL and testbench



---
 rtl/dma_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter handing the expansion bus to one DMA channel at a time while the CPU is held off through RDY.
// Optional macro X16DMA_CPU_SLOT_EN: every release returns to IDLE so the CPU gets one bus cycle between bursts.
`timescale 1ns/1ps

module dma_bus_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int CHW       = 2,
    parameter int MAX_BURST = 16,
    parameter int HALT_CYC  = 1
) (
    input  logic              PHI2,
    input  logic              RESB,
    input  logic [NUM_CH-1:0] REQ,
    output logic [NUM_CH-1:0] GNT,
    output logic              BUSEN,
    output logic              RDYOE,
    output logic [CHW-1:0]    ACTIVE_CH,
    output logic              BURST_END
);

    localparam int CNTW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        HALT,
        GRANT,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    ptr_q, ptr_d;
    logic [CHW-1:0]    active_q, active_d;
    logic [1:0]        halt_q, halt_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              busen_q, busen_d;
    logic              rdyoe_q, rdyoe_d;
    logic              bend_q, bend_d;

    logic              any_req;
    logic [CHW-1:0]    next_ptr;
    logic [CHW-1:0]    base;
    logic [CHW-1:0]    win_idx;

    assign any_req  = |REQ;
    assign next_ptr = (active_q == CHW'(NUM_CH - 1)) ? '0 : active_q + CHW'(1);
    // Leaving RELEASE arbitrates from the pointer that is being written on that same edge.
    assign base     = (state_q == RELEASE) ? next_ptr : ptr_q;

    // Scan from the highest offset down so the requester closest to base is assigned last and wins.
    always_comb begin
        win_idx = base;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (REQ[CHW'((int'(base) + i) % NUM_CH)]) begin
                win_idx = CHW'((int'(base) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        active_d = active_q;
        halt_d   = halt_q;
        cnt_d    = cnt_q;
        bend_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    active_d = win_idx;
                    halt_d   = 2'd1;
                    state_d  = HALT;
                end
            end
            HALT: begin
                if (!any_req) begin
                    state_d = RELEASE;
                end else if (halt_q == 2'(HALT_CYC)) begin
                    active_d = win_idx;
                    cnt_d    = CNTW'(1);
                    state_d  = GRANT;
                end else begin
                    halt_d = halt_q + 2'd1;
                end
            end
            GRANT: begin
                if (!REQ[active_q]) begin
                    state_d = RELEASE;
                end else if (MAX_BURST != 0 && cnt_q == CNTW'(MAX_BURST)) begin
                    state_d = RELEASE;
                    bend_d  = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            RELEASE: begin
                ptr_d = next_ptr;
`ifdef X16DMA_CPU_SLOT_EN
                state_d = IDLE;
`else
                if (any_req) begin
                    active_d = win_idx;
                    cnt_d    = CNTW'(1);
                    state_d  = GRANT;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        gnt_d = '0;
        if (state_d == GRANT) begin
            gnt_d[active_d] = 1'b1;
        end
        busen_d = (state_d == GRANT);
        rdyoe_d = (state_d != IDLE);
    end

    always_ff @(posedge PHI2) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!RESB) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            active_q <= '0;
            halt_q   <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            busen_q  <= 1'b0;
            rdyoe_q  <= 1'b0;
            bend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            active_q <= active_d;
            halt_q   <= halt_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            busen_q  <= busen_d;
            rdyoe_q  <= rdyoe_d;
            bend_q   <= bend_d;
        end
    end

    assign GNT       = gnt_q;
    assign BUSEN     = busen_q;
    assign RDYOE     = rdyoe_q;
    assign ACTIVE_CH = active_q;
    assign BURST_END = bend_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: two instances (burst-limited and unlimited) checked by
// per-scenario tasks plus a grant scoreboard fed with expected {channel, length, burst_end} records.
`timescale 1ns/1ps

module tb_dma_bus_arbiter;

    localparam int BURST_A = 4;
    localparam int HALT_A  = 2;
    localparam int BURST_B = 0;
    localparam int HALT_B  = 1;
`ifdef X16DMA_CPU_SLOT_EN
    localparam bit CPU_SLOT = 1'b1;
`else
    localparam bit CPU_SLOT = 1'b0;
`endif

    typedef struct {
        int ch;
        int len;
        bit bend;
    } grant_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic       busen_a, busen_b, rdyoe_a, rdyoe_b, bend_a, bend_b;
    logic [1:0] act_a, act_b;

    int         n_checks;
    int         n_fail;
    bit         mon_en;
    int         run_len [2];
    int         run_ch  [2];
    grant_t     exp_a [$];
    grant_t     exp_b [$];

    always #5 clk = ~clk;

    dma_bus_arbiter #(.NUM_CH(4), .CHW(2), .MAX_BURST(BURST_A), .HALT_CYC(HALT_A)) dut_a (
        .PHI2(clk), .RESB(rst_n), .REQ(req_a), .GNT(gnt_a), .BUSEN(busen_a),
        .RDYOE(rdyoe_a), .ACTIVE_CH(act_a), .BURST_END(bend_a)
    );

    dma_bus_arbiter #(.NUM_CH(4), .CHW(2), .MAX_BURST(BURST_B), .HALT_CYC(HALT_B)) dut_b (
        .PHI2(clk), .RESB(rst_n), .REQ(req_b), .GNT(gnt_b), .BUSEN(busen_b),
        .RDYOE(rdyoe_b), .ACTIVE_CH(act_b), .BURST_END(bend_b)
    );

    // Scoreboard: tracks each continuous grant and compares it with the next expected record when it ends.
    task automatic monitor_step(input int d, input logic [3:0] g, input logic be,
                                input logic rdy, input logic bend_o);
        grant_t e;
        int     ch;
        ch = -1;
        for (int i = 0; i < 4; i++) if (g[i]) ch = i;
        n_checks++;
        if (be !== (g != 4'b0000)) begin
            n_fail++;
            $display("FAIL busen_vs_gnt dut%0d: busen=%b gnt=%b", d, be, g);
        end
        if (g != 4'b0000) begin
            n_checks++;
            if (!$onehot(g) || rdy !== 1'b1 || bend_o !== 1'b0) begin
                n_fail++;
                $display("FAIL grant_shape dut%0d: gnt=%b rdyoe=%b burst_end=%b, want one-hot, 1, 0", d, g, rdy, bend_o);
            end
            n_checks++;
            if (run_len[d] != 0 && ch != run_ch[d]) begin
                n_fail++;
                $display("FAIL no_turnaround dut%0d: owner %0d -> %0d without BUSEN=0 cycle", d, run_ch[d], ch);
            end
            if (run_len[d] == 0) run_ch[d] = ch;
            run_len[d]++;
        end else if (run_len[d] != 0) begin
            n_checks++;
            if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
                n_fail++;
                $display("FAIL unexpected_grant dut%0d: ch=%0d len=%0d, none expected", d, run_ch[d], run_len[d]);
            end else begin
                e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
                if (run_ch[d] != e.ch || run_len[d] != e.len || bend_o !== e.bend) begin
                    n_fail++;
                    $display("FAIL grant_record dut%0d: got ch=%0d len=%0d burst_end=%b, want ch=%0d len=%0d burst_end=%b",
                             d, run_ch[d], run_len[d], bend_o, e.ch, e.len, e.bend);
                end
            end
            run_len[d] = 0;
        end else begin
            n_checks++;
            if (bend_o !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_burst_end dut%0d: burst_end=%b outside a grant end", d, bend_o);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            monitor_step(0, gnt_a, busen_a, rdyoe_a, bend_a);
            monitor_step(1, gnt_b, busen_b, rdyoe_b, bend_b);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 4'b0000;
        req_b = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 4'b1111;
        req_b = 4'b1111;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt_a, busen_a, rdyoe_a, act_a, bend_a} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_a: gnt=%b busen=%b rdyoe=%b act=%0d bend=%b, want all 0", gnt_a, busen_a, rdyoe_a, act_a, bend_a);
        end
        n_checks++;
        if ({gnt_b, busen_b, rdyoe_b, act_b, bend_b} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_b: gnt=%b busen=%b rdyoe=%b act=%0d bend=%b, want all 0", gnt_b, busen_b, rdyoe_b, act_b, bend_b);
        end
        rst_n  = 1'b1;
        req_a  = 4'b0000;
        req_b  = 4'b0000;
        mon_en = 1'b1;
    endtask

    // Single channel on the unlimited instance: one HALT cycle, five grant cycles, one turnaround, idle.
    task automatic test_single_request();
        exp_b.push_back('{ch: 0, len: 5, bend: 1'b0});
        req_b = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (rdyoe_b !== 1'b1 || gnt_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_halt: rdyoe=%b gnt=%b, want 1 0000", rdyoe_b, gnt_b);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (gnt_b !== 4'b0001) begin
                n_fail++;
                $display("FAIL single_grant cycle %0d: gnt=%b, want 0001", k, gnt_b);
            end
        end
        req_b = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (gnt_b !== 4'b0000 || busen_b !== 1'b0 || rdyoe_b !== 1'b1) begin
            n_fail++;
            $display("FAIL single_release: gnt=%b busen=%b rdyoe=%b, want 0000 0 1", gnt_b, busen_b, rdyoe_b);
        end
        @(negedge clk);
        n_checks++;
        if (rdyoe_b !== 1'b0 || act_b !== 2'd0) begin
            n_fail++;
            $display("FAIL single_idle: rdyoe=%b act=%0d, want 0 0", rdyoe_b, act_b);
        end
    endtask

    // One-cycle request on both instances: HALT, RELEASE, IDLE, never a grant.
    task automatic test_halt_drop();
        req_a = 4'b0100;
        req_b = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (rdyoe_a !== 1'b1 || act_a !== 2'd2 || rdyoe_b !== 1'b1 || act_b !== 2'd2) begin
            n_fail++;
            $display("FAIL halt_drop_halt: rdyoe=%b/%b act=%0d/%0d, want 1/1 2/2", rdyoe_a, rdyoe_b, act_a, act_b);
        end
        req_a = 4'b0000;
        req_b = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (rdyoe_a !== 1'b1 || rdyoe_b !== 1'b1 || gnt_a !== 4'b0000 || gnt_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL halt_drop_release: rdyoe=%b/%b gnt=%b/%b, want 1/1 0000/0000", rdyoe_a, rdyoe_b, gnt_a, gnt_b);
        end
        @(negedge clk);
        n_checks++;
        if (rdyoe_a !== 1'b0 || rdyoe_b !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_drop_idle: rdyoe=%b/%b, want 0/0", rdyoe_a, rdyoe_b);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (gnt_a !== 4'b0000 || gnt_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL halt_drop_nogrant: gnt=%b/%b, want 0000/0000", gnt_a, gnt_b);
        end
    endtask

    // Held pattern on the burst-limited instance: expected order from round-robin over the pattern,
    // each grant MAX_BURST long, and the turnaround / CPU-slot gap shape between grants.
    task automatic test_rotation(input logic [3:0] pat, input int n_grants, input string name);
        int         p, w, runs, halt_seen, gap_len, gap_low, exp_gap, exp_low;
        logic [3:0] prev;
        logic [3:0] pv;
        pv = pat;
        p  = 0;
        for (int g = 0; g < n_grants; g++) begin
            w = -1;
            for (int i = 3; i >= 0; i--) if (pv[(p + i) % 4]) w = (p + i) % 4;
            exp_a.push_back('{ch: w, len: BURST_A, bend: 1'b1});
            p = (w + 1) % 4;
        end
        exp_gap   = CPU_SLOT ? 2 + HALT_A : 1;
        exp_low   = CPU_SLOT ? 1 : 0;
        runs      = 0;
        halt_seen = 0;
        gap_len   = 0;
        gap_low   = 0;
        prev      = 4'b0000;
        req_a     = pat;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (gnt_a != 4'b0000) begin
                if (prev == 4'b0000) begin
                    n_checks++;
                    if (runs == 0 && halt_seen != HALT_A) begin
                        n_fail++;
                        $display("FAIL %s_halt_len: %0d stalled cycles before first grant, want %0d", name, halt_seen, HALT_A);
                    end else if (runs != 0 && (gap_len != exp_gap || gap_low != exp_low)) begin
                        n_fail++;
                        $display("FAIL %s_gap: gap=%0d rdy_low=%0d, want gap=%0d rdy_low=%0d", name, gap_len, gap_low, exp_gap, exp_low);
                    end
                    gap_len = 0;
                    gap_low = 0;
                end
            end else begin
                if (prev != 4'b0000) runs++;
                if (runs == 0) begin
                    if (rdyoe_a) halt_seen++;
                end else begin
                    gap_len++;
                    if (!rdyoe_a) gap_low++;
                end
                if (runs == n_grants) break;
            end
            prev = gnt_a;
        end
        n_checks++;
        if (runs != n_grants) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d grants completed, want %0d", name, runs, n_grants);
        end
        req_a = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (rdyoe_a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: rdyoe=%b, want 0", name, rdyoe_a);
        end
    endtask

    task automatic test_reset_mid_grant();
        int found;
        do_reset();
        exp_a.push_back('{ch: 1, len: 2, bend: 1'b0});
        req_a = 4'b0010;
        found = 0;
        for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
            @(negedge clk);
            if (gnt_a == 4'b0010) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL mid_reset_wait: gnt=%b, want 0010 within 20 cycles", gnt_a);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({gnt_a, busen_a, rdyoe_a, act_a, bend_a} !== 10'b0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: gnt=%b busen=%b rdyoe=%b act=%0d bend=%b, want all 0", gnt_a, busen_a, rdyoe_a, act_a, bend_a);
        end
        exp_a.push_back('{ch: 1, len: BURST_A, bend: 1'b1});
        exp_a.push_back('{ch: 3, len: 1, bend: 1'b0});
        rst_n = 1'b1;
        req_a = 4'b1010;
        @(negedge clk);
        n_checks++;
        if (act_a !== 2'd1 || rdyoe_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_winner: act=%0d rdyoe=%b, want 1 1", act_a, rdyoe_a);
        end
        found = 0;
        for (int cyc = 0; cyc < 40 && found == 0; cyc++) begin
            @(negedge clk);
            if (gnt_a == 4'b1000) found = 1;
        end
        req_a = 4'b0000;
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL mid_reset_second: gnt=%b, want 1000 within 40 cycles", gnt_a);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rdyoe_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: rdyoe=%b, want 0", rdyoe_a);
        end
    endtask

    // Unlimited burst: one 300-cycle grant with no BURST_END and no break from a counter wrap.
    task automatic test_unlimited();
        int found;
        exp_b.push_back('{ch: 0, len: 300, bend: 1'b0});
        req_b = 4'b0001;
        found = 0;
        for (int cyc = 0; cyc < 10 && found == 0; cyc++) begin
            @(negedge clk);
            if (gnt_b == 4'b0001) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL unlimited_start: gnt=%b, want 0001 within 10 cycles", gnt_b);
        end
        for (int k = 1; k < 300; k++) begin
            @(negedge clk);
            n_checks++;
            if (gnt_b !== 4'b0001 || bend_b !== 1'b0) begin
                n_fail++;
                $display("FAIL unlimited_hold cycle %0d: gnt=%b burst_end=%b, want 0001 0", k, gnt_b, bend_b);
            end
        end
        req_b = 4'b0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rdyoe_b !== 1'b0 || gnt_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL unlimited_idle: rdyoe=%b gnt=%b, want 0 0000", rdyoe_b, gnt_b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        run_len  = '{0, 0};
        run_ch   = '{0, 0};
        rst_n    = 1'b0;
        req_a    = 4'b0000;
        req_b    = 4'b0000;
        @(negedge clk);
        test_reset();
        test_single_request();
        test_halt_drop();
        do_reset();
        test_rotation(4'b1111, 5, "round_robin");
        do_reset();
        test_rotation(4'b0011, 4, "back_to_back");
        test_reset_mid_grant();
        test_unlimited();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d expected grants never seen, want 0/0", exp_a.size(), exp_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
